serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 26 ++
 rtl/serial_subtractor_full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - SS_WIDTH_DEFAULT : default operand width
//   - state_t          : control FSM states (IDLE / SHIFT / DONE)
//   - cnt_width()      : bit-counter width, $clog2(WIDTH+1), for any WIDTH
//   - SS_CNT_W_DEFAULT : bit-counter width for the default WIDTH
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int SS_WIDTH_DEFAULT = 8;

    // The counter indexes WIDTH+1 bit positions (0..WIDTH).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int SS_CNT_W_DEFAULT = $clog2(SS_WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit subtractor cell: computes x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & (y | bin)) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Recovers the first operand of a WIDTH-bit addition from the adder outputs:
// diff = {cout,sum} - b - cin, computed one bit per clock, LSB first, over
// WIDTH+1 bit positions. err flags operand sets that no WIDTH-bit addition
// could have produced (negative diff or diff wider than WIDTH bits).
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operand set on sum/cout/b/cin is valid
//   in_ready  : block is idle and accepts an operand set
//   sum       : adder sum word
//   cout      : adder carry-out
//   b         : adder second operand
//   cin       : adder carry-in
//   out_valid : result on a/err is valid (held until out_ready)
//   out_ready : consumer accepts the result
//   a         : recovered first operand, diff[WIDTH-1:0]
//   err       : operand set inconsistent with any WIDTH-bit addition
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic             err
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic [WIDTH:0]     r_x;      // {cout,sum}, shifted right each bit
    logic [WIDTH-1:0]   r_b;      // b, shifted right; zero fill supplies b bit WIDTH
    logic [WIDTH:0]     r_acc;    // result, filled from the MSB end
    logic               w_load;
    logic               w_d;
    logic               w_bout;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_load = in_valid & in_ready;

    // ------------------------------------------------------------ datapath
    full_subtractor u_fs (
        .x    (r_x[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_x      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_borrow <= cin;     // carry-in is subtracted as the initial borrow
            r_x      <= {cout, sum};
            r_b      <= b;
            r_acc    <= '0;
        end else if (r_state == SHIFT) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_borrow <= w_bout;
            r_x      <= {1'b0, r_x[WIDTH:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            // After WIDTH+1 shifts the first bit computed sits at r_acc[0].
            r_acc    <= {w_d, r_acc[WIDTH:1]};
        end
    end

    assign a   = r_acc[WIDTH-1:0];
    // A final borrow means diff went negative; a set top bit means diff
    // needed WIDTH+1 bits. Either way no WIDTH-bit addition produced it.
    assign err = r_borrow | r_acc[WIDTH];

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor (WIDTH=8). Stimulus pushes the
// expected {a,err} into a queue at each input handshake; a monitor pops and
// compares whenever an output handshake is about to occur.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic         err;

    int   checks     = 0;
    int   failures   = 0;
    int   n_expected = 0;
    int   n_seen     = 0;
    exp_t sb[$];
    exp_t mon_e;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer subtraction of the adder relation.
    function automatic exp_t model(input logic [W-1:0] s, input logic co,
                                   input logic [W-1:0] bb, input logic ci);
        int   d;
        exp_t e;
        d     = int'({co, s}) - int'(bb) - int'(ci);
        e.a   = d[W-1:0];
        e.err = (d < 0) || (d > (2**W - 1));
        return e;
    endfunction

    // Monitor: an output handshake will occur on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got a=0x%0h err=%0d expected no output", a, err);
            end else begin
                mon_e = sb.pop_front();
                check("result_a", 32'(a), 32'(mon_e.a));
                check("result_err", 32'(err), 32'(mon_e.err));
                $display("result a=0x%02h err=%0d (expected a=0x%02h err=%0d)", a, err, mon_e.a, mon_e.err);
            end
        end
    end

    // Wait for in_ready (bounded), then present one operand set for one edge.
    task automatic send(input logic [W-1:0] s, input logic co, input logic [W-1:0] bb,
                        input logic ci, input exp_t e, input bit rand_rdy);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            k++;
        end while (!in_ready && k < 100);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got in_ready=0 expected in_ready=1 within 100 cycles");
            return;
        end
        sum      = s;
        cout     = co;
        b        = bb;
        cin      = ci;
        in_valid = 1'b1;
        sb.push_back(e);
        n_expected++;
        $display("send sum=0x%02h cout=%0d b=0x%02h cin=%0d", s, co, bb, ci);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Number of falling edges after the handshake edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_timeout got out_valid=0 expected out_valid=1 within 50 cycles");
        end
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got pending=%0d expected pending=0", sb.size());
        end
    endtask

    initial begin
        int           n;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   ad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_a", 32'(a), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic result plus latency; out_ready already high on DONE entry
        send(8'h02, 1'b0, 8'h01, 1'b0, model(8'h02, 1'b0, 8'h01, 1'b0), 1'b0);
        wait_valid(n);
        check("latency", 32'(n), 32'(W + 2));
        @(posedge clk);
        #1;
        check("in_ready_after_consume", 32'(in_ready), 32'd1);

        // Boundary cases: max result, wrap through carry, negative, overflow
        send(8'hFE, 1'b1, 8'hFF, 1'b0, model(8'hFE, 1'b1, 8'hFF, 1'b0), 1'b0);
        send(8'h00, 1'b1, 8'h01, 1'b0, model(8'h00, 1'b1, 8'h01, 1'b0), 1'b0);
        send(8'h00, 1'b0, 8'h01, 1'b0, model(8'h00, 1'b0, 8'h01, 1'b0), 1'b0);
        send(8'hFF, 1'b1, 8'h00, 1'b0, model(8'hFF, 1'b1, 8'h00, 1'b0), 1'b0);
        send(8'h00, 1'b0, 8'h00, 1'b1, model(8'h00, 1'b0, 8'h00, 1'b1), 1'b0);
        drain();

        // Consumer stall in DONE with spurious in_valid pulses
        out_ready = 1'b0;
        send(8'h10, 1'b0, 8'h03, 1'b1, model(8'h10, 1'b0, 8'h03, 1'b1), 1'b0);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            sum      = W'($urandom);
            b        = W'($urandom);
            cout     = 1'($urandom);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_a", 32'(a), 32'h0C);
            check("stall_err", 32'(err), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("no_ghost_result", 32'(out_valid), 32'd0);

        // Reset in the middle of SHIFT discards the operation
        send(8'h55, 1'b0, 8'h11, 1'b0, model(8'h55, 1'b0, 8'h11, 1'b0), 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        n_expected--;
        @(posedge clk);
        #1;
        check("midreset_next_out_valid", 32'(out_valid), 32'd0);
        check("midreset_next_in_ready", 32'(in_ready), 32'd1);
        check("midreset_a", 32'(a), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        // Operand presented so the first edge after release is the handshake
        @(negedge clk);
        rst      = 1'b0;
        sum      = 8'h9A;
        cout     = 1'b0;
        b        = 8'h23;
        cin      = 1'b1;
        in_valid = 1'b1;
        sb.push_back(model(8'h9A, 1'b0, 8'h23, 1'b1));
        n_expected++;
        $display("send sum=0x9a cout=0 b=0x23 cin=1 (first edge after reset)");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("first_edge_handshake", 32'(in_ready), 32'd0);
        drain();

        // Random sweep: feed genuine adder outputs, expect the operand back
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ad = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            send(ad[W-1:0], ad[W], rb, rc, '{a: ra, err: 1'b0}, 1'b1);
        end
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("output_count", 32'(n_seen), 32'(n_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
